stepper_phase_decoder: RTL and testbench

Monitors the 4-bit half-step coil pattern driving a stepper motor and recovers step events, direction and a signed position count. It is the read-back side of the coil sequencer: it taps the coil pins (or a loop-back of them) for closed-loop checking of commanded motion on the forklift axes. Illegal patterns and skipped phases put the block in a sticky fault state, which the supervisor reads.

---
 rtl/stepper_pkg.sv | 52 +++++
 rtl/stepper_input_filter.sv | 70 +++++++
 rtl/stepper_phase_decoder.sv | 135 +++++++++++++
 tb/tb_stepper_phase_decoder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared definitions for the half-step coil sequencer and its read-back decoder:
// phase table, pattern classification and the decoder state encoding.
package stepper_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PAT_IDLE    = 2'd0,
        PAT_VALID   = 2'd1,
        PAT_ILLEGAL = 2'd2
    } pat_class_t;

    localparam logic [3:0] IDLE_PAT = 4'b0000;

    // Forward half-step order; stepping past index 7 returns to index 0.
    localparam logic [3:0] HALF_STEP_TABLE [8] = '{
        4'b0001, 4'b0011, 4'b0010, 4'b0110,
        4'b0100, 4'b1100, 4'b1000, 4'b1001
    };

    function automatic pat_class_t classify_pat(input logic [3:0] pat);
        pat_class_t cls;
        cls = PAT_ILLEGAL;
        if (pat == IDLE_PAT) begin
            cls = PAT_IDLE;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (HALF_STEP_TABLE[i] == pat) begin
                    cls = PAT_VALID;
                end
            end
        end
        return cls;
    endfunction

    // Only meaningful for patterns classified PAT_VALID; others map to 0.
    function automatic logic [2:0] pat_to_idx(input logic [3:0] pat);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (HALF_STEP_TABLE[i] == pat) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/stepper_input_filter.sv
// Synchronizes the raw coil pins and accepts a pattern once it has been seen
// STABLE_CYCLES times in a row; one strobe per change of accepted pattern.
module stepper_input_filter
    import stepper_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] coil_in,
    output logic [3:0] accept_pat,
    output logic       accept
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    logic [3:0]       sync_q [SYNC_STAGES];
    logic [3:0]       sample;
    logic [3:0]       last_sample;
    logic [3:0]       accepted_q;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] run_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 4'b0000;
            end
        end else begin
            sync_q[0] <= coil_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sample = sync_q[SYNC_STAGES-1];

    // The strobe is combinational so the decoder registers the event on the
    // same edge that completes the stable run.
    always_comb begin
        run_next = CNT_W'(1);
        if (sample == last_sample) begin
            if (run_cnt == CNT_W'(STABLE_CYCLES)) begin
                run_next = run_cnt;
            end else begin
                run_next = run_cnt + CNT_W'(1);
            end
        end
    end

    assign accept     = (run_next == CNT_W'(STABLE_CYCLES)) && (sample != accepted_q);
    assign accept_pat = sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_sample <= 4'b0000;
            run_cnt     <= '0;
            accepted_q  <= IDLE_PAT;
        end else begin
            last_sample <= sample;
            run_cnt     <= run_next;
            if (accept) begin
                accepted_q <= sample;
            end
        end
    end

endmodule

// File: rtl/stepper_phase_decoder.sv
// Read-back decoder for the half-step coil pattern: recovers steps, direction
// and a signed position, and latches a sticky fault on illegal or skipped phases.
module stepper_phase_decoder
    import stepper_pkg::*;
#(
    parameter int POS_W         = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       coil_in,
    input  logic             clr,
    output logic             step_pulse,
    output logic             dir,
    output logic [POS_W-1:0] position,
    output logic [2:0]       phase_idx,
    output logic             locked,
    output logic             err,
    output logic             illegal_pulse,
    output logic             skip_pulse
);

    logic       accept;
    logic [3:0] accept_pat;

    stepper_input_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .coil_in   (coil_in),
        .accept_pat(accept_pat),
        .accept    (accept)
    );

    state_t           state, state_nxt;
    logic [POS_W-1:0] pos_nxt;
    logic [2:0]       phase_nxt, new_idx, delta;
    logic             dir_nxt, locked_nxt, err_nxt;
    logic             step_nxt, illegal_nxt, skip_nxt;
    pat_class_t       pat_cls;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            position      <= '0;
            phase_idx     <= 3'd0;
            dir           <= 1'b0;
            locked        <= 1'b0;
            err           <= 1'b0;
            step_pulse    <= 1'b0;
            illegal_pulse <= 1'b0;
            skip_pulse    <= 1'b0;
        end else begin
            state         <= state_nxt;
            position      <= pos_nxt;
            phase_idx     <= phase_nxt;
            dir           <= dir_nxt;
            locked        <= locked_nxt;
            err           <= err_nxt;
            step_pulse    <= step_nxt;
            illegal_pulse <= illegal_nxt;
            skip_pulse    <= skip_nxt;
        end
    end

    assign pat_cls = classify_pat(accept_pat);
    assign new_idx = pat_to_idx(accept_pat);
    assign delta   = new_idx - phase_idx;

    // clr takes priority over any accept arriving in the same cycle.
    always_comb begin
        state_nxt   = state;
        pos_nxt     = position;
        phase_nxt   = phase_idx;
        dir_nxt     = dir;
        locked_nxt  = locked;
        step_nxt    = 1'b0;
        illegal_nxt = 1'b0;
        skip_nxt    = 1'b0;

        if (clr) begin
            pos_nxt = '0;
            if (state == FAULT) begin
                state_nxt = IDLE;
            end
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (pat_cls == PAT_VALID) begin
                        phase_nxt  = new_idx;
                        locked_nxt = 1'b1;
                        state_nxt  = TRACK;
                    end else if (pat_cls == PAT_ILLEGAL) begin
                        state_nxt = FAULT;
                    end
                end
                TRACK: begin
                    if (pat_cls == PAT_VALID) begin
                        if (delta == 3'd1) begin
                            pos_nxt   = position + POS_W'(1);
                            dir_nxt   = 1'b1;
                            step_nxt  = 1'b1;
                            phase_nxt = new_idx;
                        end else if (delta == 3'd7) begin
                            pos_nxt   = position - POS_W'(1);
                            dir_nxt   = 1'b0;
                            step_nxt  = 1'b1;
                            phase_nxt = new_idx;
                        end else if (delta != 3'd0) begin
                            skip_nxt  = 1'b1;
                            state_nxt = FAULT;
                        end
                    end else if (pat_cls == PAT_IDLE) begin
                        locked_nxt = 1'b0;
                        state_nxt  = IDLE;
                    end else begin
                        illegal_nxt = 1'b1;
                        state_nxt   = FAULT;
                    end
                end
                default: begin
                end
            endcase
        end

        if (state_nxt == FAULT) begin
            locked_nxt = 1'b0;
        end
        err_nxt = (state_nxt == FAULT);
    end

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Directed bench for stepper_phase_decoder: a 16-bit instance plus a 4-bit
// instance on the same stimulus to observe position wrap.
module tb_stepper_phase_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  coil_in = 4'b0000;
    logic        clr = 1'b0;

    logic        step_pulse, dir, locked, err, illegal_pulse, skip_pulse;
    logic [15:0] position;
    logic [2:0]  phase_idx;

    logic        n_step_pulse, n_dir, n_locked, n_err, n_illegal_pulse, n_skip_pulse;
    logic [3:0]  n_position;
    logic [2:0]  n_phase_idx;

    int checks = 0;
    int failures = 0;
    int step_cnt = 0;
    int illegal_cnt = 0;
    int skip_cnt = 0;
    int step_base, illegal_base, skip_base;

    always #5 clk = ~clk;

    stepper_phase_decoder #(.POS_W(16), .SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coil_in      (coil_in),
        .clr          (clr),
        .step_pulse   (step_pulse),
        .dir          (dir),
        .position     (position),
        .phase_idx    (phase_idx),
        .locked       (locked),
        .err          (err),
        .illegal_pulse(illegal_pulse),
        .skip_pulse   (skip_pulse)
    );

    stepper_phase_decoder #(.POS_W(4), .SYNC_STAGES(2), .STABLE_CYCLES(4)) dut_n (
        .clk          (clk),
        .rst_n        (rst_n),
        .coil_in      (coil_in),
        .clr          (clr),
        .step_pulse   (n_step_pulse),
        .dir          (n_dir),
        .position     (n_position),
        .phase_idx    (n_phase_idx),
        .locked       (n_locked),
        .err          (n_err),
        .illegal_pulse(n_illegal_pulse),
        .skip_pulse   (n_skip_pulse)
    );

    // Pulses are registered and one cycle wide, so each is seen on exactly one falling edge.
    always @(negedge clk) begin
        if (step_pulse)    step_cnt++;
        if (illegal_pulse) illegal_cnt++;
        if (skip_pulse)    skip_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] pat, input int cycles);
        coil_in = pat;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic markCounts();
        step_base    = step_cnt;
        illegal_base = illegal_cnt;
        skip_base    = skip_cnt;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_pos"},    32'(position),  32'd0);
        checkOutput({tag, "_phase"},  32'(phase_idx), 32'd0);
        checkOutput({tag, "_locked"}, 32'(locked),    32'd0);
        checkOutput({tag, "_err"},    32'(err),       32'd0);
        checkOutput({tag, "_dir"},    32'(dir),       32'd0);
        checkOutput({tag, "_pulses"}, 32'({step_pulse, illegal_pulse, skip_pulse}), 32'd0);
    endtask

    logic [3:0] fwd [8];

    initial begin
        fwd = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000, 4'b1001};

        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        markCounts();
        applyStimulus(4'b0001, 10);
        checkOutput("lock_locked", 32'(locked),    32'd1);
        checkOutput("lock_phase",  32'(phase_idx), 32'd0);
        checkOutput("lock_pos",    32'(position),  32'd0);
        checkOutput("lock_nostep", 32'(step_cnt - step_base), 32'd0);

        markCounts();
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(fwd[i % 8], 8);
            if (i == 7) checkOutput("narrow_pos7", 32'(n_position), 32'd7);
        end
        checkOutput("fwd_steps",   32'(step_cnt - step_base), 32'd8);
        checkOutput("fwd_dir",     32'(dir),        32'd1);
        checkOutput("fwd_pos",     32'(position),   32'd8);
        checkOutput("fwd_phase",   32'(phase_idx),  32'd0);
        checkOutput("narrow_wrap", 32'(n_position), 32'h8);

        for (int i = 7; i >= 5; i--) begin
            applyStimulus(fwd[i], 8);
        end
        checkOutput("rev_pos",    32'(position),   32'd5);
        checkOutput("rev_dir",    32'(dir),        32'd0);
        checkOutput("rev_phase",  32'(phase_idx),  32'd5);
        checkOutput("narrow_rev", 32'(n_position), 32'd5);

        markCounts();
        applyStimulus(4'b0110, 2);
        applyStimulus(4'b1100, 8);
        checkOutput("glitch_events", 32'((step_cnt - step_base) + (skip_cnt - skip_base)), 32'd0);
        checkOutput("glitch_err",    32'(err),       32'd0);
        checkOutput("glitch_phase",  32'(phase_idx), 32'd5);

        applyStimulus(4'b1001, 8);
        checkOutput("skip_pulse",  32'(skip_cnt - skip_base), 32'd1);
        checkOutput("skip_err",    32'(err),       32'd1);
        checkOutput("skip_locked", 32'(locked),    32'd0);
        checkOutput("skip_phase",  32'(phase_idx), 32'd5);
        checkOutput("skip_pos",    32'(position),  32'd5);

        applyStimulus(4'b0001, 8);
        checkOutput("fault_nostep", 32'(step_cnt - step_base), 32'd0);
        checkOutput("fault_pos",    32'(position), 32'd5);

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checkOutput("clr_err",    32'(err),      32'd0);
        checkOutput("clr_pos",    32'(position), 32'd0);
        checkOutput("clr_locked", 32'(locked),   32'd0);

        markCounts();
        applyStimulus(4'b0011, 8);
        checkOutput("relock_phase", 32'(phase_idx), 32'd1);
        checkOutput("relock_lock",  32'(locked),    32'd1);
        applyStimulus(4'b0101, 8);
        checkOutput("illegal_pulse", 32'(illegal_cnt - illegal_base), 32'd1);
        checkOutput("illegal_err",   32'(err), 32'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checkOutput("illegal_clr_err", 32'(err), 32'd0);

        applyStimulus(4'b0010, 8);
        applyStimulus(4'b0110, 8);
        checkOutput("pre_clr_pos", 32'(position), 32'd1);
        markCounts();
        applyStimulus(4'b0100, 5);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checkOutput("clrwin_pos",   32'(position),  32'd0);
        checkOutput("clrwin_phase", 32'(phase_idx), 32'd3);
        checkOutput("clrwin_lock",  32'(locked),    32'd1);
        repeat (4) @(negedge clk);
        checkOutput("clrwin_nostep", 32'(step_cnt - step_base), 32'd0);

        applyStimulus(4'b0010, 8);
        checkOutput("back_pos", 32'(position), 32'h0000FFFF);
        checkOutput("back_dir", 32'(dir),      32'd0);
        applyStimulus(4'b0000, 8);
        checkOutput("idle_lock",   32'(locked),     32'd0);
        checkOutput("idle_pos",    32'(position),   32'h0000FFFF);
        checkOutput("idle_narrow", 32'(n_position), 32'hF);
        checkOutput("idle_err",    32'(err),        32'd0);

        markCounts();
        applyStimulus(4'b0001, 3);
        #2 rst_n = 1'b0;
        #1 checkAllZero("async_rst");
        @(negedge clk);
        coil_in = 4'b0000;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("post_rst_lock",  32'(locked),    32'd0);
        checkOutput("post_rst_phase", 32'(phase_idx), 32'd0);
        checkOutput("post_rst_steps", 32'(step_cnt - step_base), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
